scramble_seq_ctrl: RTL and testbench

//  Sequencer for the FFT SignalScramble stage. On i_start, walks one N=2^ADDR_SIZE frame as
//  N/2 address pairs (A=2k, B=2k+1) and issues sample-buffer reads. Delays the pair addresses
//  to arrive with the read data at the bit-reversal stage, then issues aligned write enables.

---
 rtl/scramble_seq_ctrl_pkg.sv | 14 +
 rtl/scramble_seq_ctrl_if.sv | 33 +++
 rtl/scramble_seq_ctrl_delay_line.sv | 35 +++
 rtl/scramble_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_scramble_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/scramble_seq_ctrl_pkg.sv
// Shared definitions for the FFT SignalScramble sequencer: FSM state encoding and
// frame counter width, also used by the FFT pipeline top and the testbench.
package fft_scramble_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/scramble_seq_ctrl_if.sv
// Control/status bundle between the scramble sequencer (master) and the FFT pipeline
// top (slave): start/hold requests in, read/pipe/write strobes, addresses and status out.
interface scramble_seq_ctrl_if #(
    parameter int ADDR_SIZE = 5
);
    import fft_scramble_pkg::*;

    logic                   i_start;
    logic                   i_hold;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_rd_en;
    logic [ADDR_SIZE-1:0]   o_rdaddr_A;
    logic [ADDR_SIZE-1:0]   o_rdaddr_B;
    logic                   o_pipe_valid;
    logic [ADDR_SIZE-1:0]   o_pipeaddr_A;
    logic [ADDR_SIZE-1:0]   o_pipeaddr_B;
    logic                   o_wr_en;
    logic [FRAME_CNT_W-1:0] o_frame_cnt;

    modport master (
        input  i_start, i_hold,
        output o_busy, o_done, o_rd_en, o_rdaddr_A, o_rdaddr_B,
               o_pipe_valid, o_pipeaddr_A, o_pipeaddr_B, o_wr_en, o_frame_cnt
    );

    modport slave (
        output i_start, i_hold,
        input  o_busy, o_done, o_rd_en, o_rdaddr_A, o_rdaddr_B,
               o_pipe_valid, o_pipeaddr_A, o_pipeaddr_B, o_wr_en, o_frame_cnt
    );

endinterface

// File: rtl/scramble_seq_ctrl_delay_line.sv
// Fixed-depth shift register with async active-low clear; it never stalls because the
// stages it models (buffer read, bit-reversal) have no enable.
module scramble_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = d_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign d_out = stage_q[DEPTH-1];

endmodule

// File: rtl/scramble_seq_ctrl.sv
// Scramble-stage sequencer: issues N/2 read pairs per frame and delays them to the write side.
// Optional completed-frame counter is built only when SCRAMBLE_FRAME_CNT_EN is defined.
module scramble_seq_ctrl
    import fft_scramble_pkg::*;
#(
    parameter int ADDR_SIZE = 5,
    parameter int RD_LAT    = 1,
    parameter int PIPE_LAT  = 1
) (
    input logic                 i_CLK,
    input logic                 i_RST_N,
    scramble_seq_ctrl_if.master bus
);

    localparam int K_W     = ADDR_SIZE - 1;
    localparam int DRAIN_W = $clog2(RD_LAT + PIPE_LAT);
    localparam int LINE_W  = 1 + 2 * ADDR_SIZE;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RD_LAT + PIPE_LAT - 1);

    state_e               state_q, state_d;
    logic [K_W-1:0]       k_q, k_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic                 rd_en_q, rd_en_d;
    logic [ADDR_SIZE-1:0] rdaddr_a_q, rdaddr_a_d;
    logic [ADDR_SIZE-1:0] rdaddr_b_q, rdaddr_b_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Status flags are derived from the next state so they line up with the state register.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        drain_cnt_d = drain_cnt_q;
        rd_en_d     = 1'b0;
        rdaddr_a_d  = rdaddr_a_q;
        rdaddr_b_d  = rdaddr_b_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!bus.i_hold) begin
                    rd_en_d    = 1'b1;
                    rdaddr_a_d = {k_q, 1'b0};
                    rdaddr_b_d = {k_q, 1'b1};
                    k_d        = k_q + K_W'(1);
                    if (&k_q) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            drain_cnt_q <= '0;
            rd_en_q     <= 1'b0;
            rdaddr_a_q  <= '0;
            rdaddr_b_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            drain_cnt_q <= drain_cnt_d;
            rd_en_q     <= rd_en_d;
            rdaddr_a_q  <= rdaddr_a_d;
            rdaddr_b_q  <= rdaddr_b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    logic [LINE_W-1:0] rd_bundle;
    logic [LINE_W-1:0] pipe_bundle;
    logic              pipe_valid;
    logic              wr_en;

    assign rd_bundle = {rd_en_q, rdaddr_a_q, rdaddr_b_q};

    scramble_delay_line #(.WIDTH(LINE_W), .DEPTH(RD_LAT)) u_rd_to_pipe (
        .clk   (i_CLK),
        .rst_n (i_RST_N),
        .d_in  (rd_bundle),
        .d_out (pipe_bundle)
    );

    assign pipe_valid = pipe_bundle[LINE_W-1];

    scramble_delay_line #(.WIDTH(1), .DEPTH(PIPE_LAT)) u_pipe_to_wr (
        .clk   (i_CLK),
        .rst_n (i_RST_N),
        .d_in  (pipe_valid),
        .d_out (wr_en)
    );

    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
    assign bus.o_rd_en      = rd_en_q;
    assign bus.o_rdaddr_A   = rdaddr_a_q;
    assign bus.o_rdaddr_B   = rdaddr_b_q;
    assign bus.o_pipe_valid = pipe_valid;
    assign bus.o_pipeaddr_A = pipe_bundle[2*ADDR_SIZE-1:ADDR_SIZE];
    assign bus.o_pipeaddr_B = pipe_bundle[ADDR_SIZE-1:0];
    assign bus.o_wr_en      = wr_en;

`ifdef SCRAMBLE_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (state_q == S_DONE) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.o_frame_cnt = frame_cnt_q;
`else
    assign bus.o_frame_cnt = '0;
`endif

endmodule

// File: tb/tb_scramble_seq_ctrl.sv
// Randomized self-checking bench for scramble_seq_ctrl: a default-configuration DUT plus a
// small-configuration DUT, checked against a pair-schedule model built from the frame rules.
module tb_scramble_seq_ctrl;
    import fft_scramble_pkg::*;

    localparam int AS  = 5;
    localparam int RL  = 1;
    localparam int PL  = 1;
    localparam int NP  = 1 << (AS - 1);
    localparam int AS2 = 3;
    localparam int RL2 = 2;
    localparam int PL2 = 3;
    localparam int NP2 = 1 << (AS2 - 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   vectors      = 0;
    int   miscompares  = 0;
    int   frames_model = 0;

    always #5 clk = ~clk;

    scramble_seq_ctrl_if #(.ADDR_SIZE(AS))  bus  ();
    scramble_seq_ctrl_if #(.ADDR_SIZE(AS2)) bus2 ();

    scramble_seq_ctrl #(.ADDR_SIZE(AS), .RD_LAT(RL), .PIPE_LAT(PL)) dut (
        .i_CLK   (clk),
        .i_RST_N (rst_n),
        .bus     (bus)
    );

    scramble_seq_ctrl #(.ADDR_SIZE(AS2), .RD_LAT(RL2), .PIPE_LAT(PL2)) dut_small (
        .i_CLK   (clk),
        .i_RST_N (rst_n),
        .bus     (bus2)
    );

    task automatic cycle(input logic start, input logic hold);
        bus.i_start = start;
        bus.i_hold  = hold;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Model: every edge after the start edge issues the next pair unless held; the write side
    // sees the same schedule shifted by the fixed latencies, and done lands on the last write.
    task automatic run_frame(input string name, input int hold_pct, input int hold_from,
                             input int hold_len, input int start_pct);
        int   pair_of [0:599];
        logic hold_v  [0:599];
        int   issued, last_e, done_c, p, pp, pw, exp_fc;
        logic st;
        for (int i = 0; i < 600; i++) begin
            pair_of[i] = -1;
            hold_v[i]  = 1'b0;
        end
        issued = 0;
        last_e = 0;
        for (int e = 1; issued < NP; e++) begin
            if (e >= hold_from && e < hold_from + hold_len) hold_v[e] = 1'b1;
            else if (e < 300) hold_v[e] = (int'($urandom_range(99)) < hold_pct);
            if (!hold_v[e]) begin
                pair_of[e] = issued;
                issued++;
            end
            last_e = e;
        end
        done_c = last_e + RL + PL;
        for (int e = last_e + 1; e <= done_c + 1; e++) hold_v[e] = ($urandom_range(1) == 1);

        cycle(1'b1, ($urandom_range(1) == 1));
        vectors++;
        if ({bus.o_busy, bus.o_rd_en, bus.o_done} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL %s start_state: busy/rd_en/done got %b want 100", name,
                     {bus.o_busy, bus.o_rd_en, bus.o_done});
        end
        for (int c = 1; c <= done_c + 1; c++) begin
            st = (int'($urandom_range(99)) < start_pct);
            cycle(st, hold_v[c]);
            p  = pair_of[c];
            pp = (c >= RL) ? pair_of[c-RL] : -1;
            pw = (c >= RL + PL) ? pair_of[c-RL-PL] : -1;
`ifdef SCRAMBLE_FRAME_CNT_EN
            exp_fc = frames_model & 16'hFFFF;
`else
            exp_fc = 0;
`endif
            vectors++;
            if (bus.o_rd_en !== (p >= 0)) begin
                miscompares++;
                $display("[TB] FAIL %s rd_en cycle %0d: got %b want %b", name, c, bus.o_rd_en, p >= 0);
            end
            if (p >= 0) begin
                vectors++;
                if (bus.o_rdaddr_A !== AS'(2*p) || bus.o_rdaddr_B !== AS'(2*p+1)) begin
                    miscompares++;
                    $display("[TB] FAIL %s rdaddr cycle %0d: got (%0d,%0d) want (%0d,%0d)", name, c,
                             bus.o_rdaddr_A, bus.o_rdaddr_B, 2*p, 2*p+1);
                end
            end
            vectors++;
            if (bus.o_pipe_valid !== (pp >= 0)) begin
                miscompares++;
                $display("[TB] FAIL %s pipe_valid cycle %0d: got %b want %b", name, c, bus.o_pipe_valid, pp >= 0);
            end
            if (pp >= 0) begin
                vectors++;
                if (bus.o_pipeaddr_A !== AS'(2*pp) || bus.o_pipeaddr_B !== AS'(2*pp+1)) begin
                    miscompares++;
                    $display("[TB] FAIL %s pipeaddr cycle %0d: got (%0d,%0d) want (%0d,%0d)", name, c,
                             bus.o_pipeaddr_A, bus.o_pipeaddr_B, 2*pp, 2*pp+1);
                end
            end
            vectors++;
            if (bus.o_wr_en !== (pw >= 0)) begin
                miscompares++;
                $display("[TB] FAIL %s wr_en cycle %0d: got %b want %b", name, c, bus.o_wr_en, pw >= 0);
            end
            vectors++;
            if ({bus.o_done, bus.o_busy} !== {(c == done_c), (c <= done_c)}) begin
                miscompares++;
                $display("[TB] FAIL %s done/busy cycle %0d: got %b%b want %b%b", name, c,
                         bus.o_done, bus.o_busy, c == done_c, c <= done_c);
            end
            vectors++;
            if (bus.o_frame_cnt !== 16'(exp_fc)) begin
                miscompares++;
                $display("[TB] FAIL %s frame_cnt cycle %0d: got %0d want %0d", name, c, bus.o_frame_cnt, exp_fc);
            end
            if (c == done_c) frames_model++;
        end
        bus.i_start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_rdaddr_A, bus.o_rdaddr_B, bus.o_pipe_valid,
             bus.o_pipeaddr_A, bus.o_pipeaddr_B, bus.o_wr_en, bus.o_frame_cnt} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got busy=%b rd_en=%b wr_en=%b fc=%0d want all zero",
                     bus.o_busy, bus.o_rd_en, bus.o_wr_en, bus.o_frame_cnt);
        end
        vectors++;
        if ({bus2.o_busy, bus2.o_done, bus2.o_rd_en, bus2.o_pipe_valid, bus2.o_wr_en} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs_small: got %b want 00000",
                     {bus2.o_busy, bus2.o_done, bus2.o_rd_en, bus2.o_pipe_valid, bus2.o_wr_en});
        end
        rst_n = 1'b1;
        cycle(1'b0, 1'b1);
        vectors++;
        if ({bus.o_busy, bus.o_rd_en} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL idle_no_start: busy/rd_en got %b want 00", {bus.o_busy, bus.o_rd_en});
        end
    endtask

    task automatic test_no_hold();
        run_frame("no_hold", 0, 0, 0, 0);
    endtask

    task automatic test_hold_window();
        run_frame("hold_after_pair8", 0, 10, 3, 0);
    endtask

    task automatic test_restart_ignored();
        run_frame("restart_ignored", 0, 0, 0, 60);
    endtask

    task automatic test_random_hold();
        for (int i = 0; i < 3; i++) run_frame("random_hold", 30, 0, 0, 20);
    endtask

    task automatic test_back_to_back();
        run_frame("back_to_back_1", 15, 0, 0, 0);
        run_frame("back_to_back_2", 15, 0, 0, 0);
    endtask

    task automatic test_reset_mid_frame();
        cycle(1'b1, 1'b0);
        for (int c = 1; c <= 6; c++) cycle(1'b0, 1'b0);
        vectors++;
        if (bus.o_rdaddr_A !== AS'(10)) begin
            miscompares++;
            $display("[TB] FAIL mid_frame_pair5: rdaddr_A got %0d want 10", bus.o_rdaddr_A);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if ({bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_rdaddr_A, bus.o_rdaddr_B, bus.o_pipe_valid,
                 bus.o_pipeaddr_A, bus.o_pipeaddr_B, bus.o_wr_en, bus.o_frame_cnt} !== '0) begin
                miscompares++;
                $display("[TB] FAIL async_reset step %0d: got busy=%b done=%b rd_en=%b wr_en=%b want all zero",
                         c, bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_wr_en);
            end
            if (c < 2) cycle(1'b0, 1'b0);
        end
        rst_n = 1'b1;
        frames_model = 0;
        run_frame("after_reset", 0, 0, 0, 0);
    endtask

    task automatic test_small_config();
        int p, pp, pw, done_c;
        done_c = NP2 + RL2 + PL2;
        bus2.i_hold  = 1'b0;
        bus2.i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus2.i_start = 1'b0;
        for (int c = 1; c <= done_c + 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            p  = (c >= 1 && c <= NP2) ? c - 1 : -1;
            pp = (c - RL2 >= 1 && c - RL2 <= NP2) ? c - RL2 - 1 : -1;
            pw = (c - RL2 - PL2 >= 1 && c - RL2 - PL2 <= NP2) ? c - RL2 - PL2 - 1 : -1;
            vectors++;
            if ({bus2.o_rd_en, bus2.o_pipe_valid, bus2.o_wr_en} !== {(p >= 0), (pp >= 0), (pw >= 0)}) begin
                miscompares++;
                $display("[TB] FAIL small_strobes cycle %0d: rd/pipe/wr got %b want %b%b%b", c,
                         {bus2.o_rd_en, bus2.o_pipe_valid, bus2.o_wr_en}, p >= 0, pp >= 0, pw >= 0);
            end
            if (p >= 0) begin
                vectors++;
                if (bus2.o_rdaddr_A !== AS2'(2*p) || bus2.o_rdaddr_B !== AS2'(2*p+1)) begin
                    miscompares++;
                    $display("[TB] FAIL small_rdaddr cycle %0d: got (%0d,%0d) want (%0d,%0d)", c,
                             bus2.o_rdaddr_A, bus2.o_rdaddr_B, 2*p, 2*p+1);
                end
            end
            if (pp >= 0) begin
                vectors++;
                if (bus2.o_pipeaddr_A !== AS2'(2*pp) || bus2.o_pipeaddr_B !== AS2'(2*pp+1)) begin
                    miscompares++;
                    $display("[TB] FAIL small_pipeaddr cycle %0d: got (%0d,%0d) want (%0d,%0d)", c,
                             bus2.o_pipeaddr_A, bus2.o_pipeaddr_B, 2*pp, 2*pp+1);
                end
            end
            vectors++;
            if ({bus2.o_done, bus2.o_busy} !== {(c == done_c), (c <= done_c)}) begin
                miscompares++;
                $display("[TB] FAIL small_done_busy cycle %0d: got %b%b want %b%b", c,
                         bus2.o_done, bus2.o_busy, c == done_c, c <= done_c);
            end
        end
    endtask

    initial begin
        bus.i_start  = 1'b0;
        bus.i_hold   = 1'b0;
        bus2.i_start = 1'b0;
        bus2.i_hold  = 1'b0;
        #1 rst_n = 1'b0;
        test_reset();
        test_no_hold();
        test_hold_window();
        test_restart_ignored();
        test_random_hold();
        test_back_to_back();
        test_reset_mid_frame();
        test_small_config();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
